// File: rtl/demux_pkg.sv
// Shared types and default sizes for the registered N-channel demux.
package demux_pkg;

  localparam int unsigned DEMUX_DATA_W = 4;
  localparam int unsigned DEMUX_N_CH   = 8;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

endpackage

// File: rtl/demux_n_reg_if.sv
// Bus bundle between a word source and the registered demux.
interface demux_n_reg_if
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEMUX_DATA_W,
  parameter int unsigned N_CH   = DEMUX_N_CH
);

  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [DATA_W-1:0]      inData;
  logic [SEL_W-1:0]       inSel;
  logic                   inValid;
  logic                   inMode;
  logic                   inClear;
  logic [N_CH-1:0]        inRead;
  logic [N_CH*DATA_W-1:0] outData;
  logic [N_CH-1:0]        outValid;
  logic                   outFrame;
  logic                   outOvf;

  modport master (
    output inData, inSel, inValid, inMode, inClear, inRead,
    input  outData, outValid, outFrame, outOvf
  );

  modport slave (
    input  inData, inSel, inValid, inMode, inClear, inRead,
    output outData, outValid, outFrame, outOvf
  );

endinterface

// File: rtl/demux_ch_reg.sv
// One output channel: data register, valid bit and overwrite detect.
module demux_ch_reg #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_q,
  output logic              ovf_det_c
);

  logic [DATA_W-1:0] data_d;
  logic              valid_d;

  // Next state: clear wins, then write (which also absorbs a same-cycle read), then read.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    ovf_det_c = wr_en & valid_q & ~rd_en;
    if (clear) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (wr_en) begin
      data_d  = wr_data;
      valid_d = 1'b1;
    end else if (rd_en) begin
      valid_d = 1'b0;
    end
  end

  // Channel registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/demux_n_reg.sv
// Registered 1-to-N demux with addressed and round-robin routing.
module demux_n_reg
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEMUX_DATA_W,
  parameter int unsigned N_CH   = DEMUX_N_CH
) (
  input logic          clk,
  input logic          resetn,
  demux_n_reg_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(N_CH);

  mode_e                  mode;
  logic                   accept;
  logic [SEL_W-1:0]       target;
  logic [N_CH-1:0]        wr_vec;
  logic [N_CH-1:0]        rd_vec;
  logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   frame_q, frame_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_W-1:0]      ch_data [N_CH];
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH-1:0]        ch_ovf_det;
  logic [N_CH*DATA_W-1:0] out_data_c;

  // Target decode, round-robin pointer, frame pulse and sticky overflow.
  always_comb begin
    mode     = mode_e'(bus.inMode);
    accept   = bus.inValid & ~bus.inClear;
    target   = (mode == MODE_RR) ? rr_ptr_q : bus.inSel;
    rd_vec   = bus.inRead & {N_CH{~bus.inClear}};
    wr_vec   = '0;
    rr_ptr_d = rr_ptr_q;
    frame_d  = 1'b0;
    ovf_d    = ovf_q | (|ch_ovf_det);
    for (int unsigned k = 0; k < N_CH; k++) begin
      wr_vec[k] = accept && (target == SEL_W'(k));
    end
    if (bus.inClear) begin
      rr_ptr_d = '0;
      ovf_d    = 1'b0;
    end else if (accept && (mode == MODE_RR)) begin
      rr_ptr_d = rr_ptr_q + SEL_W'(1);
      frame_d  = (rr_ptr_q == SEL_W'(N_CH - 1));
    end
  end

  // Top-level registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
      frame_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      frame_q  <= frame_d;
      ovf_q    <= ovf_d;
    end
  end

  // One register slice per channel.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    demux_ch_reg #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (bus.inClear),
      .wr_en     (wr_vec[g]),
      .rd_en     (rd_vec[g]),
      .wr_data   (bus.inData),
      .data_q    (ch_data[g]),
      .valid_q   (ch_valid[g]),
      .ovf_det_c (ch_ovf_det[g])
    );
  end

  // Pack channel registers into the flat output bus.
  always_comb begin
    out_data_c = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      out_data_c[k*DATA_W +: DATA_W] = ch_data[k];
    end
  end

  assign bus.outData  = out_data_c;
  assign bus.outValid = ch_valid;
  assign bus.outFrame = frame_q;
  assign bus.outOvf   = ovf_q;

endmodule
